axi_lite_master: RTL and testbench

- Single-outstanding AXI-lite initiator that converts a simple command/response interface into AXI-lite read and write transactions.
- Sits between a local controller (register sequencer, test driver, CPU-side bridge) and the team's AXI-lite slave register/memory blocks.
- Accepts one command at a time, drives the AW/W/B or AR/R channels, and returns the read data or write status on a response port.

---
 rtl/axi_lite_master_if.sv | 69 ++++++
 rtl/axi_lite_master.sv | 138 +++++++++++++
 tb/tb_axi_lite_master.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_if.sv
// rtl/axi_lite_master_if.sv - command/response and AXI-lite channel bundle for axi_lite_master
// The master modport is the initiator side; slave is the controller plus AXI slave side.
interface axi_lite_master_if #(
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_WD-1:0] cmd_addr;
  logic [DATA_WD-1:0] cmd_wdata;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_write;
  logic [DATA_WD-1:0] rsp_rdata;
  logic [1:0]         rsp_resp;

  logic [ADDR_WD-1:0] awaddr;
  logic               awvalid;
  logic               awready;
  logic [DATA_WD-1:0] wdata;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [ADDR_WD-1:0] araddr;
  logic               arvalid;
  logic               arready;
  logic [DATA_WD-1:0] rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  rsp_ready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output rsp_ready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI-lite initiator behind a command/response port
// One command in flight; AW/W complete independently before the B phase is opened.
module axi_lite_master #(
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 8
) (
  input  logic               clk,
  input  logic               rstn,
  axi_lite_master_if.master  bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               arvalid_q, arvalid_d;
  logic [ADDR_WD-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WD-1:0] araddr_q, araddr_d;
  logic [DATA_WD-1:0] wdata_q, wdata_d;
  logic [DATA_WD-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_resp_q, rsp_resp_d;
  logic               rsp_write_q, rsp_write_d;
  logic               aw_done, w_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    aw_done     = 1'b0;
    w_done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_write) begin
            awaddr_d  = bus.cmd_addr;
            wdata_d   = bus.cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR;
          end else begin
            araddr_d  = bus.cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WADDR: begin
        // A channel whose valid is already low has completed its handshake.
        if (awvalid_q && bus.awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
        aw_done = !awvalid_d;
        w_done  = !wvalid_d;
        if (aw_done && w_done) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (bus.bvalid) begin
          rsp_resp_d  = bus.bresp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RADDR: begin
        if (arvalid_q && bus.arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (bus.rvalid) begin
          rsp_rdata_d = bus.rdata;
          rsp_resp_d  = bus.rresp;
          rsp_write_d = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.bready    = (state_q == S_WRESP);
  assign bus.rready    = (state_q == S_RDATA);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.awaddr    = awaddr_q;
  assign bus.awvalid   = awvalid_q;
  assign bus.wdata     = wdata_q;
  assign bus.wvalid    = wvalid_q;
  assign bus.araddr    = araddr_q;
  assign bus.arvalid   = arvalid_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - scoreboard bench for axi_lite_master with a delay-configurable AXI-lite slave
module tb_axi_lite_master;
  logic clk;
  logic rstn;
  int   cyc;
  int   n_cmp;
  int   n_err;

  axi_lite_master_if #(.DATA_WD(32), .ADDR_WD(8)) bus();

  axi_lite_master #(.DATA_WD(32), .ADDR_WD(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          acc;
    bit          zw;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] mem [256];

  int         aw_dly, w_dly, ar_dly, r_dly, b_dly, rsp_dly;
  logic [1:0] cfg_resp;

  int aw_hi, w_hi, b_fires;
  int rsp_fires, last_fire_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // AXI-lite slave with per-channel ready/valid delays plus protocol observer
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, rs_cnt;
  bit          aw_got, w_got, ar_got, b_act, r_act;
  bit          aw_f, w_f, ar_f, b_f, r_f;
  bit          p_awv, p_wv, p_arv;
  logic [7:0]  p_awaddr, p_araddr, s_addr, r_addr;
  logic [31:0] p_wdata, s_data;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.rvalid = 1'b0;
    bus.rresp = 2'b00; bus.rdata = 32'h0; bus.rsp_ready = 1'b0;
    aw_hi = 0; w_hi = 0; b_fires = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rstn) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; rs_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_act = 0; r_act = 0;
        aw_f = 0; w_f = 0; ar_f = 0; b_f = 0; r_f = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.rvalid = 1'b0; bus.rsp_ready = 1'b0;
      end else begin
        if (aw_f) begin aw_got = 1; s_addr = p_awaddr; end
        if (w_f)  begin w_got = 1; s_data = p_wdata; end
        if (b_f)  begin mem[s_addr] = s_data; aw_got = 0; w_got = 0; b_act = 0; b_cnt = 0; b_fires++; end
        if (ar_f) begin ar_got = 1; r_addr = p_araddr; end
        if (r_f)  begin ar_got = 0; r_act = 0; r_cnt = 0; end

        if (p_awv && !aw_f) begin
          chk("awvalid_hold", 32'(bus.awvalid), 32'd1);
          chk("awaddr_stable", 32'(bus.awaddr), 32'(p_awaddr));
        end
        if (aw_f) chk("awvalid_drop", 32'(bus.awvalid), 32'd0);
        if (p_wv && !w_f) begin
          chk("wvalid_hold", 32'(bus.wvalid), 32'd1);
          chk("wdata_stable", bus.wdata, p_wdata);
        end
        if (w_f) chk("wvalid_drop", 32'(bus.wvalid), 32'd0);
        if (p_arv && !ar_f) begin
          chk("arvalid_hold", 32'(bus.arvalid), 32'd1);
          chk("araddr_stable", 32'(bus.araddr), 32'(p_araddr));
        end
        if (ar_f) chk("arvalid_drop", 32'(bus.arvalid), 32'd0);
        if (bus.bready) chk("bready_after_aw_w", 32'(aw_got && w_got), 32'd1);
        if (bus.rready) chk("rready_after_ar", 32'(ar_got), 32'd1);
        if (bus.awvalid || bus.arvalid)
          chk("aw_ar_exclusive", 32'(bus.awvalid && bus.arvalid), 32'd0);

        if (bus.awvalid) begin aw_hi++; bus.awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin bus.awready = 1'b0; aw_cnt = 0; end
        if (bus.wvalid) begin w_hi++; bus.wready = (w_cnt >= w_dly); w_cnt++; end
        else begin bus.wready = 1'b0; w_cnt = 0; end
        if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_dly); ar_cnt++; end
        else begin bus.arready = 1'b0; ar_cnt = 0; end

        if (aw_got && w_got && !b_act) begin
          if (b_cnt >= b_dly) b_act = 1; else b_cnt++;
        end
        bus.bvalid = b_act;
        bus.bresp  = b_act ? cfg_resp : 2'b00;
        if (ar_got && !r_act) begin
          if (r_cnt >= r_dly) r_act = 1; else r_cnt++;
        end
        bus.rvalid = r_act;
        bus.rdata  = r_act ? mem[r_addr] : 32'h0;
        bus.rresp  = r_act ? cfg_resp : 2'b00;

        if (bus.rsp_valid) begin bus.rsp_ready = (rs_cnt >= rsp_dly); rs_cnt++; end
        else begin bus.rsp_ready = 1'b0; rs_cnt = 0; end

        aw_f = bus.awvalid && bus.awready;
        w_f  = bus.wvalid && bus.wready;
        ar_f = bus.arvalid && bus.arready;
        b_f  = bus.bvalid && bus.bready;
        r_f  = bus.rvalid && bus.rready;
        p_awv = bus.awvalid; p_awaddr = bus.awaddr;
        p_wv  = bus.wvalid;  p_wdata  = bus.wdata;
        p_arv = bus.arvalid; p_araddr = bus.araddr;
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake
  initial begin
    bit          p_rv, p_rf;
    logic [31:0] p_rdata;
    logic [1:0]  p_resp;
    logic        p_write;
    int          first_cyc;
    exp_t        e;
    p_rv = 0; p_rf = 0; first_cyc = 0; rsp_fires = 0; last_fire_cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        p_rv = 0; p_rf = 0;
      end else begin
        if (p_rv && !p_rf) begin
          chk("rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
          chk("rsp_rdata_stable", bus.rsp_rdata, p_rdata);
          chk("rsp_resp_stable", 32'(bus.rsp_resp), 32'(p_resp));
          chk("rsp_write_stable", 32'(bus.rsp_write), 32'(p_write));
        end
        if (bus.rsp_valid) chk("cmd_ready_low_in_resp", 32'(bus.cmd_ready), 32'd0);
        if (bus.rsp_valid && !p_rv) first_cyc = cyc;
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rsp_unexpected: actual=response with empty scoreboard required=no response");
          end else begin
            e = exp_q.pop_front();
            chk("rsp_write", 32'(bus.rsp_write), 32'(e.wr));
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_resp", 32'(bus.rsp_resp), 32'(e.resp));
            if (e.zw) chk("zero_wait_latency", 32'(first_cyc - e.acc), 32'd3);
          end
          last_fire_cyc = cyc;
          rsp_fires++;
        end
        p_rf    = bus.rsp_valid && bus.rsp_ready;
        p_rv    = bus.rsp_valid;
        p_rdata = bus.rsp_rdata;
        p_resp  = bus.rsp_resp;
        p_write = bus.rsp_write;
      end
    end
  end

  task automatic set_dly(input int aw, input int w, input int ar, input int r, input int b, input int rs);
    aw_dly = aw; w_dly = w; ar_dly = ar; r_dly = r; b_dly = b; rsp_dly = rs;
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [1:0] r, output int acc);
    exp_t e;
    int   t;
    cfg_resp = r;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: actual=cmd_ready low for %0d cycles required=accept", t);
      acc = -1;
    end else begin
      acc     = cyc;
      e.wr    = wr;
      e.rdata = wr ? 32'h0 : ref_mem[a];
      e.resp  = r;
      e.acc   = acc;
      e.zw    = (aw_dly == 0) && (w_dly == 0) && (ar_dly == 0) && (r_dly == 0) && (b_dly == 0);
      if (wr) ref_mem[a] = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_timeout: actual=%0d responses outstanding required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
    int acc;
    issue(wr, a, d, r, acc);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    int          h_aw, h_w, h_b, acc1, acc2;
    logic [31:0] saved;
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    set_dly(0, 0, 0, 0, 0, 0);
    cfg_resp = 2'b00;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h0; bus.cmd_wdata = 32'h0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset_awvalid", 32'(bus.awvalid), 32'd0);
    chk("reset_wvalid", 32'(bus.wvalid), 32'd0);
    chk("reset_arvalid", 32'(bus.arvalid), 32'd0);
    chk("reset_bready", 32'(bus.bready), 32'd0);
    chk("reset_rready", 32'(bus.rready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_resp", 32'(bus.rsp_resp), 32'd0);
    chk("reset_rsp_write", 32'(bus.rsp_write), 32'd0);
    chk("reset_awaddr", 32'(bus.awaddr), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    h_aw = aw_hi; h_w = w_hi;
    run(1'b1, 8'h10, 32'hDEADBEEF, 2'b00);
    chk("zw_awvalid_cycles", 32'(aw_hi - h_aw), 32'd1);
    chk("zw_wvalid_cycles", 32'(w_hi - h_w), 32'd1);
    run(1'b0, 8'h10, 32'h0, 2'b00);

    set_dly(3, 0, 0, 0, 0, 0);
    h_aw = aw_hi; h_w = w_hi; h_b = b_fires;
    run(1'b1, 8'h30, 32'hA5A5_0003, 2'b00);
    chk("awdly_awvalid_cycles", 32'(aw_hi - h_aw), 32'd4);
    chk("awdly_wvalid_cycles", 32'(w_hi - h_w), 32'd1);
    chk("awdly_b_handshakes", 32'(b_fires - h_b), 32'd1);

    set_dly(0, 2, 0, 0, 0, 0);
    h_aw = aw_hi; h_w = w_hi; h_b = b_fires;
    run(1'b1, 8'h50, 32'h5A5A_0002, 2'b01);
    chk("wdly_awvalid_cycles", 32'(aw_hi - h_aw), 32'd1);
    chk("wdly_wvalid_cycles", 32'(w_hi - h_w), 32'd3);
    chk("wdly_b_handshakes", 32'(b_fires - h_b), 32'd1);

    set_dly(0, 0, 0, 0, 0, 0);
    run(1'b1, 8'hFF, 32'h12345678, 2'b00);
    set_dly(0, 0, 0, 5, 0, 0);
    run(1'b0, 8'hFF, 32'h0, 2'b10);

    set_dly(0, 0, 0, 0, 0, 4);
    issue(1'b1, 8'h20, 32'h0BAD_F00D, 2'b00, acc1);
    issue(1'b0, 8'h20, 32'h0, 2'b00, acc2);
    chk("accept_first_idle_cycle", 32'(acc2 - last_fire_cyc), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_done();

    set_dly(10, 0, 0, 0, 0, 0);
    saved = ref_mem[8'h40];
    issue(1'b1, 8'h40, 32'hCAFE0001, 2'b00, acc1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("awvalid_before_reset", 32'(bus.awvalid), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_awvalid", 32'(bus.awvalid), 32'd0);
    chk("rst_wvalid", 32'(bus.wvalid), 32'd0);
    chk("rst_bready", 32'(bus.bready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_awaddr", 32'(bus.awaddr), 32'd0);
    exp_q.delete();
    ref_mem[8'h40] = saved;
    set_dly(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    run(1'b0, 8'h10, 32'h0, 2'b00);

    for (int n = 0; n < 40; n++) begin
      set_dly($urandom_range(0, 1) ? $urandom_range(0, 3) : 0,
              $urandom_range(0, 1) ? $urandom_range(0, 3) : 0,
              $urandom_range(0, 1) ? $urandom_range(0, 3) : 0,
              $urandom_range(0, 1) ? $urandom_range(0, 3) : 0,
              $urandom_range(0, 1) ? $urandom_range(0, 3) : 0,
              $urandom_range(0, 2));
      run(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15) * 16), $urandom,
          2'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
